// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: FSM state encoding and sizing helper.
package scan_decoder_pkg;

   // IDLE: nothing decoded, MANUAL: holding a loaded code, SCAN: stepping codes
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   // Width of a counter that must hold 0..n-1; never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_decoder_onehot.sv
// Combinational code -> one-hot decoder, OUT_W = 2**SEL_W. Shared with older 3-to-8 designs.
module onehot_decode #(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0]      i_sel,
   output logic [(2**SEL_W)-1:0] o_onehot
);

   // Place a single 1 at the selected bit position
   always_comb begin
      o_onehot        = '0;
      o_onehot[i_sel] = 1'b1;
   end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N decoder with a manual (valid/ready load) mode and an auto-scan
// mode that walks every code, holding each for DWELL clocks. All outputs are registered.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter int DWELL      = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic                  i_mode,
   input  logic [SEL_W-1:0]      i_sel_in,
   input  logic                  i_sel_valid,
   output logic                  o_sel_ready,
   output logic [(2**SEL_W)-1:0] o_dec_out,
   output logic [SEL_W-1:0]      o_cur_sel,
   output logic                  o_wrap
);

   localparam int OUT_W = 2**SEL_W;
   localparam int DW_W  = cnt_w(DWELL);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
   // Pattern driven when no line is selected
   localparam logic [OUT_W-1:0] DEC_IDLE   = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

   state_t             r_state, w_state_nxt;
   logic [SEL_W-1:0]   r_cur_sel, w_cur_nxt;
   logic [DW_W-1:0]    r_dwell, w_dwell_nxt;
   logic [OUT_W-1:0]   r_dec, w_dec_nxt;
   logic               r_wrap, w_wrap_nxt;
   logic               r_sel_ready, w_ready_nxt;
   logic               w_show;
   logic               w_xfer;
   logic [OUT_W-1:0]   w_onehot;
   logic [OUT_W-1:0]   w_dec_active;

   // Manual load only when the previous cycle advertised ready and we are still manual+enabled
   assign w_xfer = i_sel_valid & r_sel_ready & i_en & ~i_mode;

   // Decode the code that will be current after this edge, so dec_out and cur_sel agree
   onehot_decode #(.SEL_W(SEL_W)) u_dec (
      .i_sel    (w_cur_nxt),
      .o_onehot (w_onehot)
   );

   assign w_dec_active = ACTIVE_LOW ? ~w_onehot : w_onehot;
   assign w_dec_nxt    = w_show ? w_dec_active : DEC_IDLE;

   // Next-state logic: mode beats a pending load; en=0 freezes everything and blanks the output
   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur_sel;
      w_dwell_nxt = r_dwell;
      w_wrap_nxt  = 1'b0;
      w_ready_nxt = i_en & ~i_mode;
      w_show      = 1'b0;
      if (i_en) begin
         if (i_mode) begin
            if (r_state != ST_SCAN) begin
               w_state_nxt = ST_SCAN;
               w_cur_nxt   = '0;
               w_dwell_nxt = '0;
            end else if (r_dwell == DWELL_LAST) begin
               w_dwell_nxt = '0;
               w_cur_nxt   = r_cur_sel + 1'b1;
               w_wrap_nxt  = &r_cur_sel;
            end else begin
               w_dwell_nxt = r_dwell + 1'b1;
            end
         end else if (r_state == ST_SCAN) begin
            w_state_nxt = ST_IDLE;
         end else if (w_xfer) begin
            w_state_nxt = ST_MANUAL;
            w_cur_nxt   = i_sel_in;
         end
         w_show = (w_state_nxt != ST_IDLE);
      end
   end

   // State and output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_cur_sel   <= '0;
         r_dwell     <= '0;
         r_dec       <= DEC_IDLE;
         r_wrap      <= 1'b0;
         r_sel_ready <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cur_sel   <= w_cur_nxt;
         r_dwell     <= w_dwell_nxt;
         r_dec       <= w_dec_nxt;
         r_wrap      <= w_wrap_nxt;
         r_sel_ready <= w_ready_nxt;
      end
   end

   assign o_sel_ready = r_sel_ready;
   assign o_dec_out   = r_dec;
   assign o_cur_sel   = r_cur_sel;
   assign o_wrap      = r_wrap;

endmodule
